// File: rtl/nonce_sweep_ctrl.sv
// Job controller in front of the doublesha core: sweeps an inclusive nonce range,
// checks each hash against the target and reports the first hit, exhaustion or abort.
module nonce_sweep_ctrl #(
    parameter int NONCE_W = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       job_valid,
    output logic                       job_ready,
    input  logic [607:0]               job_header,
    input  logic [255:0]               job_target,
    input  logic [NONCE_W-1:0]         job_nonce_start,
    input  logic [NONCE_W-1:0]         job_nonce_end,
    input  logic                       abort,
    output logic                       sha_start_tick,
    output logic [608+NONCE_W-1:0]     sha_block_info,
    input  logic                       sha_complete,
    input  logic [255:0]               sha_hash,
    output logic                       busy,
    output logic                       result_valid,
    output logic                       result_found,
    output logic                       result_aborted,
    output logic [NONCE_W-1:0]         result_nonce,
    output logic [255:0]               result_hash,
    output logic [31:0]                hashes_done
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_CHECK} state_t;

    state_t               state, state_nxt;
    logic [607:0]         header_q;
    logic [255:0]         target_q;
    logic [255:0]         hash_q;
    logic [NONCE_W-1:0]   nonce_q;
    logic [NONCE_W-1:0]   end_q;
    logic                 cpl_prev;
    logic                 capture;
    logic                 hit;
    logic                 last;

    function automatic logic [NONCE_W-1:0] byte_swap(input logic [NONCE_W-1:0] v);
        logic [NONCE_W-1:0] r;
        r = '0;
        for (int i = 0; i < NONCE_W/8; i++)
            r[8*i +: 8] = v[NONCE_W-8-8*i +: 8];
        return r;
    endfunction

    assign sha_block_info = {header_q, byte_swap(nonce_q)};
    // Only a fresh rising edge counts, so a level-style complete left over from
    // the previous hash is not mistaken for the current one.
    assign capture        = sha_complete && !cpl_prev;
    assign hit            = (hash_q <= target_q);
    assign last           = (nonce_q == end_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        job_ready      = 1'b0;
        busy           = 1'b1;
        sha_start_tick = 1'b0;
        case (state)
            S_IDLE: begin
                job_ready = 1'b1;
                busy      = 1'b0;
                if (job_valid) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                sha_start_tick = 1'b1;
                state_nxt      = abort ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (abort)        state_nxt = S_IDLE;
                else if (capture) state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (hit || abort || last) state_nxt = S_IDLE;
                else                      state_nxt = S_ISSUE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            header_q       <= '0;
            target_q       <= '0;
            hash_q         <= '0;
            nonce_q        <= '0;
            end_q          <= '0;
            cpl_prev       <= 1'b0;
            result_valid   <= 1'b0;
            result_found   <= 1'b0;
            result_aborted <= 1'b0;
            result_nonce   <= '0;
            result_hash    <= '0;
            hashes_done    <= '0;
        end else begin
            result_valid <= 1'b0;
            // A dropped in-flight hash may still complete later; pretend the line
            // was already high so its edge is never taken as a fresh result.
            cpl_prev     <= (abort && state != S_IDLE) ? 1'b1 : sha_complete;
            case (state)
                S_IDLE: begin
                    if (job_valid) begin
                        header_q    <= job_header;
                        target_q    <= job_target;
                        nonce_q     <= job_nonce_start;
                        end_q       <= job_nonce_end;
                        hashes_done <= '0;
                    end
                end
                S_ISSUE, S_WAIT: begin
                    if (abort) begin
                        result_valid   <= 1'b1;
                        result_found   <= 1'b0;
                        result_aborted <= 1'b1;
                        result_nonce   <= nonce_q;
                        result_hash    <= '0;
                    end else if (state == S_WAIT && capture) begin
                        hash_q <= sha_hash;
                    end
                end
                S_CHECK: begin
                    if (!(&hashes_done)) hashes_done <= hashes_done + 32'd1;
                    if (hit || abort || last) begin
                        result_valid   <= 1'b1;
                        result_found   <= hit;
                        result_aborted <= !hit && abort;
                        result_nonce   <= nonce_q;
                        result_hash    <= hash_q;
                    end else begin
                        nonce_q <= nonce_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nonce_sweep_ctrl.sv
// Directed bench for nonce_sweep_ctrl with a small doublesha core model that
// answers in pulse or level style.
module tb_nonce_sweep_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         job_valid = 1'b0;
    logic         job_ready;
    logic [607:0] job_header = '0;
    logic [255:0] job_target = '0;
    logic [31:0]  job_nonce_start = '0;
    logic [31:0]  job_nonce_end = '0;
    logic         abort = 1'b0;
    logic         sha_start_tick;
    logic [639:0] sha_block_info;
    logic         sha_complete;
    logic [255:0] sha_hash;
    logic         busy;
    logic         result_valid;
    logic         result_found;
    logic         result_aborted;
    logic [31:0]  result_nonce;
    logic [255:0] result_hash;
    logic [31:0]  hashes_done;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    nonce_sweep_ctrl #(.NONCE_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_header(job_header), .job_target(job_target),
        .job_nonce_start(job_nonce_start), .job_nonce_end(job_nonce_end),
        .abort(abort),
        .sha_start_tick(sha_start_tick), .sha_block_info(sha_block_info),
        .sha_complete(sha_complete), .sha_hash(sha_hash),
        .busy(busy), .result_valid(result_valid), .result_found(result_found),
        .result_aborted(result_aborted), .result_nonce(result_nonce),
        .result_hash(result_hash), .hashes_done(hashes_done)
    );

    function automatic logic [31:0] swap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // core model: hash = nonce on the chosen hit nonce, else ~nonce (huge)
    logic         level_mode = 1'b0;
    logic         hit_en = 1'b0;
    logic [31:0]  hit_nonce = '0;
    logic         m_busy, start_d;
    logic [3:0]   m_cnt;
    logic [31:0]  m_nonce;
    logic [639:0] last_blk;
    logic [31:0]  nlog [0:255];
    int           n_starts;

    always @(posedge clk_i) begin
        start_d <= sha_start_tick;
        if (rst_i) begin
            sha_complete <= 1'b0;
            sha_hash     <= '0;
            m_busy       <= 1'b0;
            m_cnt        <= '0;
            n_starts     <= 0;
        end else if (sha_start_tick) begin
            m_busy   <= 1'b1;
            m_cnt    <= 4'd3;
            m_nonce  <= swap32(sha_block_info[31:0]);
            last_blk <= sha_block_info;
            nlog[n_starts[7:0]] <= swap32(sha_block_info[31:0]);
            n_starts <= n_starts + 1;
            if (!level_mode) sha_complete <= 1'b0;
        end else if (m_busy) begin
            if (start_d) sha_complete <= 1'b0;
            if (m_cnt == 0) begin
                sha_complete <= 1'b1;
                sha_hash     <= (hit_en && m_nonce == hit_nonce) ? 256'(m_nonce) : ~256'(m_nonce);
                m_busy       <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 4'd1;
            end
        end else if (!level_mode) begin
            sha_complete <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_job(input logic [607:0] hdr, input logic [255:0] tgt,
                            input logic [31:0] s, input logic [31:0] e);
        @(negedge clk_i);
        job_header = hdr; job_target = tgt;
        job_nonce_start = s; job_nonce_end = e;
        job_valid = 1'b1;
        @(negedge clk_i);
        job_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        bit seen = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk_i);
            if (result_valid) seen = 1;
        end
        if (!seen) chk({tag, "_timeout"}, 0, 1);
    endtask

    logic [607:0] hdr;
    int           base;
    int           rv_cnt;
    bit           found_evt;

    initial begin
        hdr = {19{32'hA5C3_1F02}};
        repeat (3) @(negedge clk_i);
        chk("rst_ready", job_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_start", sha_start_tick, 0);
        chk("rst_blk", sha_block_info, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_hd", hashes_done, 0);
        chk("rst_rnonce", result_nonce, 0);
        rst_i = 1'b0;

        // any hit on a single-nonce range
        base = n_starts;
        send_job(hdr, '1, 32'h1234_5678, 32'h1234_5678);
        wait_result("t1");
        chk("t1_starts", n_starts - base, 1);
        chk("t1_blk_lo", last_blk[31:0], 32'h7856_3412);
        chk("t1_blk_hdr", last_blk[639:32], hdr);
        chk("t1_found", result_found, 1);
        chk("t1_abort", result_aborted, 0);
        chk("t1_nonce", result_nonce, 32'h1234_5678);
        chk("t1_hash", result_hash, ~256'h1234_5678);
        chk("t1_hd", hashes_done, 1);
        @(negedge clk_i);
        chk("t1_rv_pulse", result_valid, 0);
        chk("t1_ready", job_ready, 1);

        // no hit, 5..9
        base = n_starts;
        send_job(hdr, '0, 32'd5, 32'd9);
        wait_result("t2");
        chk("t2_starts", n_starts - base, 5);
        for (int i = 0; i < 5; i++) chk($sformatf("t2_n%0d", i), nlog[8'(base + i)], 32'(5 + i));
        chk("t2_found", result_found, 0);
        chk("t2_nonce", result_nonce, 9);
        chk("t2_hash", result_hash, ~256'd9);
        chk("t2_hd", hashes_done, 5);

        // mid-range hit at 7
        hit_en = 1'b1; hit_nonce = 32'd7;
        base = n_starts;
        send_job(hdr, 256'd100, 32'd3, 32'd20);
        wait_result("t3");
        chk("t3_found", result_found, 1);
        chk("t3_nonce", result_nonce, 7);
        chk("t3_hash", result_hash, 256'd7);
        chk("t3_hd", hashes_done, 5);
        repeat (10) @(negedge clk_i);
        chk("t3_starts", n_starts - base, 5);
        hit_en = 1'b0;

        // wrap with level-style complete
        level_mode = 1'b1;
        base = n_starts;
        send_job(hdr, '0, 32'hFFFF_FFFE, 32'd1);
        wait_result("t4");
        chk("t4_starts", n_starts - base, 4);
        chk("t4_n0", nlog[8'(base)],     32'hFFFF_FFFE);
        chk("t4_n1", nlog[8'(base + 1)], 32'hFFFF_FFFF);
        chk("t4_n2", nlog[8'(base + 2)], 32'h0);
        chk("t4_n3", nlog[8'(base + 3)], 32'h1);
        chk("t4_found", result_found, 0);
        chk("t4_nonce", result_nonce, 1);
        chk("t4_hash", result_hash, ~256'd1);
        chk("t4_hd", hashes_done, 4);

        // level complete no-hit run repeated: one capture per nonce
        base = n_starts;
        send_job(hdr, '0, 32'd5, 32'd9);
        wait_result("t5");
        chk("t5_starts", n_starts - base, 5);
        chk("t5_hd", hashes_done, 5);
        chk("t5_hash", result_hash, ~256'd9);
        level_mode = 1'b0;

        // abort in WAIT at nonce 4, then an immediate new job
        send_job(hdr, '0, 32'd2, 32'd10);
        found_evt = 0;
        for (int i = 0; i < 200 && !found_evt; i++) begin
            @(negedge clk_i);
            if (sha_start_tick && swap32(sha_block_info[31:0]) == 32'd4) found_evt = 1;
        end
        if (!found_evt) chk("t6_issue4_timeout", 0, 1);
        @(posedge clk_i); #1;
        abort = 1'b1;
        @(posedge clk_i); #1;
        abort = 1'b0;
        chk("t6_rv", result_valid, 1);
        chk("t6_aborted", result_aborted, 1);
        chk("t6_found", result_found, 0);
        chk("t6_nonce", result_nonce, 4);
        chk("t6_hd", hashes_done, 2);
        job_header = hdr; job_target = '1;
        job_nonce_start = 32'h20; job_nonce_end = 32'h20;
        job_valid = 1'b1;
        @(posedge clk_i); #1;
        job_valid = 1'b0;
        chk("t6_busy", busy, 1);
        wait_result("t6b");
        chk("t6b_found", result_found, 1);
        chk("t6b_aborted", result_aborted, 0);
        chk("t6b_nonce", result_nonce, 32'h20);
        chk("t6b_hash", result_hash, ~256'h20);
        chk("t6b_hd", hashes_done, 1);

        // abort together with a hit in CHECK
        hit_en = 1'b1; hit_nonce = 32'd3;
        send_job(hdr, 256'd100, 32'd3, 32'd20);
        found_evt = 0;
        for (int i = 0; i < 200 && !found_evt; i++) begin
            @(negedge clk_i);
            if (sha_complete) found_evt = 1;
        end
        if (!found_evt) chk("t7_cpl_timeout", 0, 1);
        @(posedge clk_i); #1;
        abort = 1'b1;
        @(posedge clk_i); #1;
        abort = 1'b0;
        chk("t7_rv", result_valid, 1);
        chk("t7_found", result_found, 1);
        chk("t7_aborted", result_aborted, 0);
        chk("t7_nonce", result_nonce, 3);
        chk("t7_hd", hashes_done, 1);
        hit_en = 1'b0;

        // reset mid-job: back to reset state, no result pulse
        send_job(hdr, '0, 32'd0, 32'd100);
        repeat (20) @(negedge clk_i);
        chk("t8_busy_pre", busy, 1);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        chk("t8_ready", job_ready, 1);
        chk("t8_busy", busy, 0);
        chk("t8_blk", sha_block_info, 0);
        chk("t8_hd", hashes_done, 0);
        chk("t8_rnonce", result_nonce, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        rv_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_i);
            if (result_valid || sha_start_tick) rv_cnt++;
        end
        chk("t8_quiet", rv_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
